// File: rtl/fetch_unit.sv
// Instruction fetch stage: one outstanding imem request, IF/ID register and a one-word skid.
// Optional branch delay slot: define FETCH_DELAY_SLOT_EN.
module fetch_unit #(
    parameter logic [31:0] RESET_PC_87 = 32'h0000_0000
) (
    input  logic        clk_87,
    input  logic        rst_87,
    input  logic        stall_87,
    input  logic        branch_taken_87,
    input  logic [31:0] br_target_87,
    input  logic [1:0]  jump_sel_87,
    input  logic [31:0] j_target_87,
    input  logic [31:0] jr_target_87,
    output logic        imem_req_87,
    output logic [31:0] imem_addr_87,
    input  logic [31:0] imem_rdata_87,
    input  logic        imem_valid_87,
    output logic [31:0] instr_87,
    output logic        instr_valid_87,
    output logic [31:0] pc_plus4_87,
    output logic [5:0]  op_87,
    output logic [5:0]  fn_87
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        SKID  = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] pc, pc_nxt, pc_inc;
    logic [31:0] skid_instr, skid_instr_nxt;
    logic [31:0] skid_pc4, skid_pc4_nxt;
    logic        disc, disc_nxt;
    logic [31:0] disc_target, disc_target_nxt;
    logic [31:0] instr_nxt, pc4_nxt;
    logic        valid_nxt;
    logic        redirect, slot_free;
    logic [31:0] target;

    // Branch beats JR beats J; jump_sel 2'b11 behaves as sequential.
    assign redirect  = !stall_87 && (branch_taken_87 || jump_sel_87 == 2'b01 || jump_sel_87 == 2'b10);
    assign target    = (branch_taken_87        ? br_target_87 :
                        jump_sel_87 == 2'b10   ? jr_target_87 : j_target_87) & 32'hFFFF_FFFC;
    assign slot_free = !stall_87 || !instr_valid_87;
    assign pc_inc    = pc + 32'd4;

    assign imem_req_87  = (state == FETCH);
    assign imem_addr_87 = pc;
    assign op_87        = instr_87[31:26];
    assign fn_87        = instr_87[5:0];

    always_comb begin
        state_nxt       = state;
        pc_nxt          = pc;
        skid_instr_nxt  = skid_instr;
        skid_pc4_nxt    = skid_pc4;
        disc_nxt        = disc;
        disc_target_nxt = disc_target;
        instr_nxt       = instr_87;
        pc4_nxt         = pc_plus4_87;
        valid_nxt       = instr_valid_87;
        case (state)
            IDLE: state_nxt = FETCH;
            FETCH: begin
`ifdef FETCH_DELAY_SLOT_EN
                // disc marks a redirect waiting for its delay-slot word to return.
                if (redirect) disc_target_nxt = target;
                if (imem_valid_87) begin
                    pc_nxt   = redirect ? target : (disc ? disc_target : pc_inc);
                    disc_nxt = 1'b0;
                    if (slot_free) begin
                        instr_nxt = imem_rdata_87;
                        pc4_nxt   = pc_inc;
                        valid_nxt = 1'b1;
                    end else begin
                        skid_instr_nxt = imem_rdata_87;
                        skid_pc4_nxt   = pc_inc;
                        state_nxt      = SKID;
                    end
                end else begin
                    if (redirect) disc_nxt = 1'b1;
                    if (slot_free) begin
                        instr_nxt = '0;
                        valid_nxt = 1'b0;
                    end
                end
`else
                if (redirect) begin
                    instr_nxt = '0;
                    valid_nxt = 1'b0;
                    if (imem_valid_87) begin
                        pc_nxt   = target;
                        disc_nxt = 1'b0;
                    end else begin
                        disc_nxt        = 1'b1;
                        disc_target_nxt = target;
                    end
                end else if (disc) begin
                    // Stale sequential response: drop it, then fetch the latched target.
                    if (slot_free) begin
                        instr_nxt = '0;
                        valid_nxt = 1'b0;
                    end
                    if (imem_valid_87) begin
                        pc_nxt   = disc_target;
                        disc_nxt = 1'b0;
                    end
                end else if (imem_valid_87) begin
                    pc_nxt = pc_inc;
                    if (slot_free) begin
                        instr_nxt = imem_rdata_87;
                        pc4_nxt   = pc_inc;
                        valid_nxt = 1'b1;
                    end else begin
                        skid_instr_nxt = imem_rdata_87;
                        skid_pc4_nxt   = pc_inc;
                        state_nxt      = SKID;
                    end
                end else if (slot_free) begin
                    instr_nxt = '0;
                    valid_nxt = 1'b0;
                end
`endif
            end
            SKID: begin
`ifdef FETCH_DELAY_SLOT_EN
                if (redirect) pc_nxt = target;
                if (!stall_87) begin
                    instr_nxt = skid_instr;
                    pc4_nxt   = skid_pc4;
                    valid_nxt = 1'b1;
                    state_nxt = FETCH;
                end
`else
                if (redirect) begin
                    pc_nxt    = target;
                    instr_nxt = '0;
                    valid_nxt = 1'b0;
                    state_nxt = FETCH;
                end else if (!stall_87) begin
                    instr_nxt = skid_instr;
                    pc4_nxt   = skid_pc4;
                    valid_nxt = 1'b1;
                    state_nxt = FETCH;
                end
`endif
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_87) begin
        if (rst_87) begin
            state          <= IDLE;
            pc             <= RESET_PC_87 & 32'hFFFF_FFFC;
            skid_instr     <= '0;
            skid_pc4       <= '0;
            disc           <= 1'b0;
            disc_target    <= '0;
            instr_87       <= '0;
            instr_valid_87 <= 1'b0;
            pc_plus4_87    <= '0;
        end else begin
            state          <= state_nxt;
            pc             <= pc_nxt;
            skid_instr     <= skid_instr_nxt;
            skid_pc4       <= skid_pc4_nxt;
            disc           <= disc_nxt;
            disc_target    <= disc_target_nxt;
            instr_87       <= instr_nxt;
            instr_valid_87 <= valid_nxt;
            pc_plus4_87    <= pc4_nxt;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit: a program-flow model predicts the instruction stream the decode stage consumes.
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC    = 32'h0000_0000;
    localparam int          RAND_CYCLES = 4000;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        branch_taken;
    logic [31:0] br_target;
    logic [1:0]  jump_sel;
    logic [31:0] j_target;
    logic [31:0] jr_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_valid;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] pc_plus4;
    logic [5:0]  op;
    logic [5:0]  fn;

    fetch_unit #(.RESET_PC_87(RESET_PC)) dut (
        .clk_87(clk), .rst_87(rst), .stall_87(stall),
        .branch_taken_87(branch_taken), .br_target_87(br_target),
        .jump_sel_87(jump_sel), .j_target_87(j_target), .jr_target_87(jr_target),
        .imem_req_87(imem_req), .imem_addr_87(imem_addr),
        .imem_rdata_87(imem_rdata), .imem_valid_87(imem_valid),
        .instr_87(instr), .instr_valid_87(instr_valid), .pc_plus4_87(pc_plus4),
        .op_87(op), .fn_87(fn)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    // Address of the next instruction the decode stage must consume, in program order.
    logic [31:0] exp_q[$];
    logic [31:0] last_addr;
`ifdef FETCH_DELAY_SLOT_EN
    bit          pend;
    logic [31:0] pend_tgt;
`endif
    int wait_left;
    bit zero_wait;
    bit force_valid;
    bit rst_last;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a < 32'h10) return 32'h2008_0005;
        return (a * 32'h9E37_79B1) ^ 32'hC3A5_0F1E;
    endfunction

    function automatic logic [31:0] rand_target();
        case ($urandom_range(0, 3))
            0:       return 32'hFFFF_FFF8;
            1:       return 32'h0000_0040;
            2:       return 32'h0000_0080;
            default: return $urandom & 32'h0000_FFFC;
        endcase
    endfunction

    // Memory: answers a held request after 0..3 wait cycles; toggles junk valid when nothing is requested.
    task automatic mem_step();
        if (force_valid) begin
            imem_valid  = 1'b1;
            imem_rdata  = $urandom;
            force_valid = 1'b0;
        end else if (imem_req) begin
            if (wait_left == 0) begin
                imem_valid = 1'b1;
                imem_rdata = mem_word(imem_addr);
                wait_left  = zero_wait ? 0 : $urandom_range(0, 3);
            end else begin
                imem_valid = 1'b0;
                imem_rdata = $urandom;
                wait_left--;
            end
        end else begin
            imem_valid = 1'($urandom_range(0, 1));
            imem_rdata = $urandom;
        end
    endtask

    task automatic cycle(input bit rnd);
        bit          idle;
        bit          consume;
        bit          redir;
        logic [31:0] tgt;
        @(negedge clk);
        mem_step();
        idle     = rst_last;
        rst      = 1'b0;
        rst_last = 1'b0;
        redir    = 1'b0;
        tgt      = '0;
        br_target = rand_target();
        j_target  = rand_target();
        jr_target = rand_target();
        if (rnd && !idle && imem_req && !imem_valid && $urandom_range(0, 59) == 0) begin
            rst          = 1'b1;
            rst_last     = 1'b1;
            stall        = 1'($urandom_range(0, 1));
            branch_taken = 1'b0;
            jump_sel     = 2'b00;
            exp_q.delete();
            exp_q.push_back(RESET_PC);
            last_addr    = RESET_PC;
`ifdef FETCH_DELAY_SLOT_EN
            pend         = 1'b0;
`endif
            wait_left    = $urandom_range(0, 3);
            force_valid  = 1'b1;
            return;
        end
        stall   = rnd ? ($urandom_range(0, 9) < 3) : 1'b0;
        consume = instr_valid && !stall;
        if (rnd && !idle && !stall && $urandom_range(0, 9) < 2) redir = 1'b1;
`ifdef FETCH_DELAY_SLOT_EN
        if (!consume || pend) redir = 1'b0;
`endif
        if (redir) begin
            branch_taken = ($urandom_range(0, 2) == 0);
            if (branch_taken) jump_sel = 2'($urandom_range(0, 3));
            else jump_sel = $urandom_range(0, 1) ? 2'b01 : 2'b10;
            tgt = branch_taken ? br_target : (jump_sel == 2'b10 ? jr_target : j_target);
        end else if (stall) begin
            branch_taken = 1'($urandom_range(0, 1));
            jump_sel     = 2'($urandom_range(0, 3));
        end else begin
            branch_taken = 1'b0;
            jump_sel     = $urandom_range(0, 1) ? 2'b11 : 2'b00;
        end
        if (consume) begin
`ifdef FETCH_DELAY_SLOT_EN
            if (pend) begin
                last_addr = pend_tgt;
                pend      = 1'b0;
            end else begin
                last_addr = last_addr + 32'd4;
                if (redir) begin
                    pend     = 1'b1;
                    pend_tgt = tgt;
                end
            end
`else
            last_addr = redir ? tgt : last_addr + 32'd4;
`endif
            exp_q.push_back(last_addr);
        end else if (redir && exp_q.size() > 0) begin
            last_addr = tgt;
            exp_q[exp_q.size() - 1] = tgt;
        end
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; branch_taken = 1'b0; jump_sel = 2'b00;
        br_target = '0; j_target = '0; jr_target = '0;
        imem_valid = 1'b0; imem_rdata = '0;
        exp_q.push_back(RESET_PC);
        last_addr = RESET_PC;
`ifdef FETCH_DELAY_SLOT_EN
        pend = 1'b0; pend_tgt = '0;
`endif
        wait_left = 0; zero_wait = 1'b1; force_valid = 1'b0;
        repeat (3) begin
            @(negedge clk);
            mem_step();
        end
        rst_last = 1'b1;
        cycle(1'b0);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0);
            check("seq_req", {31'b0, imem_req}, 32'd1);
            check("seq_addr", imem_addr, RESET_PC + 32'(4 * i));
            if (i == 1) begin
                check("first_instr", instr, 32'h2008_0005);
                check("first_valid", {31'b0, instr_valid}, 32'd1);
                check("first_op", {26'b0, op}, 32'h0000_0008);
            end
        end
        zero_wait = 1'b0;
        for (int i = 0; i < RAND_CYCLES; i++) cycle(1'b1);
        for (int i = 0; i < 40; i++) cycle(1'b0);
        @(posedge clk);
        #2;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin : monitor
        logic        have_prev, p_req, p_valid, first_pending, redir_in;
        logic [31:0] p_addr, p_instr, p_pc4, e, w;
        logic [5:0]  p_op, p_fn;
        int          idle_cycles;
        have_prev = 1'b0; first_pending = 1'b0; idle_cycles = 0;
        p_req = 1'b0; p_valid = 1'b0; p_addr = '0; p_instr = '0; p_pc4 = '0; p_op = '0; p_fn = '0;
        forever begin
            @(posedge clk);
            #1;
            redir_in = !stall && (branch_taken || jump_sel == 2'b01 || jump_sel == 2'b10);
            if (rst) begin
                check("rst_req", {31'b0, imem_req}, 32'd0);
                check("rst_instr", instr, 32'd0);
                check("rst_valid", {31'b0, instr_valid}, 32'd0);
                check("rst_pc_plus4", pc_plus4, 32'd0);
                first_pending = 1'b1;
                idle_cycles   = 0;
            end else if (have_prev) begin
                if (p_valid && !stall) begin
                    idle_cycles = 0;
                    if (exp_q.size() == 0) begin
                        checks++;
                        $display("FAIL stream: instruction %h consumed, expected none", p_instr);
                    end else begin
                        e = exp_q.pop_front();
                        w = mem_word(e);
                        check("stream_instr", p_instr, w);
                        check("stream_pc_plus4", p_pc4, e + 32'd4);
                        check("stream_op", {26'b0, p_op}, {26'b0, w[31:26]});
                        check("stream_fn", {26'b0, p_fn}, {26'b0, w[5:0]});
                    end
                end else begin
                    idle_cycles++;
                    if (idle_cycles > 100) begin
                        checks++;
                        $display("FAIL progress: no instruction consumed for %0d cycles, limit 100", idle_cycles);
                        idle_cycles = 0;
                    end
                end
                if (p_valid && stall) begin
                    check("hold_instr", instr, p_instr);
                    check("hold_valid", {31'b0, instr_valid}, 32'd1);
                    check("hold_pc_plus4", pc_plus4, p_pc4);
                    check("hold_opfn", {20'b0, op, fn}, {20'b0, p_op, p_fn});
                end
                if (p_req && !imem_valid) begin
                    check("req_held", {31'b0, imem_req}, 32'd1);
                    check("addr_stable", imem_addr, p_addr);
                end
                if (p_req && imem_valid && p_valid && stall)
                    check("skid_req_low", {31'b0, imem_req}, 32'd0);
                if (!p_req && p_valid && !stall) begin
                    check("skid_resume_req", {31'b0, imem_req}, 32'd1);
`ifdef FETCH_DELAY_SLOT_EN
                    check("skid_release_valid", {31'b0, instr_valid}, 32'd1);
`else
                    if (!redir_in) check("skid_release_valid", {31'b0, instr_valid}, 32'd1);
`endif
                end
`ifndef FETCH_DELAY_SLOT_EN
                if (redir_in) begin
                    check("bubble_instr", instr, 32'd0);
                    check("bubble_valid", {31'b0, instr_valid}, 32'd0);
                end
`endif
                if (first_pending && imem_req) begin
                    check("post_reset_addr", imem_addr, RESET_PC);
                    first_pending = 1'b0;
                end
            end
            have_prev = 1'b1;
            p_req   = imem_req;
            p_valid = instr_valid;
            p_addr  = imem_addr;
            p_instr = instr;
            p_pc4   = pc_plus4;
            p_op    = op;
            p_fn    = fn;
        end
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC_87, default 32'h0000_0000: first fetch address after reset.
REQ-002 clk_87  in  1  single clock; all state updates on rising edge.
REQ-003 rst_87  in  1  reset, synchronous, active-high.
REQ-004 stall_87  in  1  decode stage not consuming IF/ID this cycle.
REQ-005 branch_taken_87  in  1  resolved taken branch (BEQ/BNE) from decode.
REQ-006 br_target_87  in  32  branch target address.
REQ-007 jump_sel_87  in  2  00 sequential, 01 J, 10 JR, 11 treated as 00.
REQ-008 j_target_87  in  32  J target; jr_target_87 in 32 JR target (rs value).
REQ-009 imem_req_87  out  1  instruction memory request.
REQ-010 imem_addr_87  out  32  request address, word aligned.
REQ-011 imem_rdata_87  in  32  returned instruction; imem_valid_87 in 1 qualifies it.
REQ-012 instr_87  out  32  IF/ID instruction; instr_valid_87 out 1 qualifies it.
REQ-013 pc_plus4_87  out  32  address of instr_87 plus 4.
REQ-014 op_87  out  6  instr_87[31:26]; fn_87 out 6 instr_87[5:0], for the control unit.

Function
REQ-015 States: IDLE, FETCH (one request outstanding), SKID (fetched word held, no request).
REQ-016 IDLE -> FETCH on the first edge with rst_87 low; imem_req_87 high only in FETCH.
REQ-017 Exactly one outstanding request; imem_addr_87 equals PC and stays stable until imem_valid_87.
REQ-018 IF/ID loads when stall_87 low or instr_valid_87 low ("slot free").
REQ-019 FETCH, imem_valid_87, slot free: IF/ID <= {rdata, PC+4, valid}; PC <= PC+4; stay FETCH; next request next cycle.
REQ-020 FETCH, imem_valid_87, slot blocked: skid <= {rdata, PC+4}; PC <= PC+4; -> SKID.
REQ-021 SKID, stall_87 low: IF/ID <= skid; -> FETCH.
REQ-022 Redirect accepted only when stall_87 low; priority branch_taken_87 > JR > J; jump_sel 11 ignored.
REQ-023 Redirect in FETCH without imem_valid_87: target latched; PC and address unchanged; the pending response is discarded on arrival; PC <= target; stay FETCH.
REQ-024 Redirect coincident with imem_valid_87: response discarded; PC <= target next edge.
REQ-025 Redirect in SKID: skid discarded; PC <= target; -> FETCH.
REQ-026 On accepted redirect, IF/ID loads a bubble next edge (instr_87 = 0, instr_valid_87 = 0).
REQ-027 A second redirect while a discard is pending overwrites the latched target.
REQ-028 stall_87 high with IF/ID valid: IF/ID, pc_plus4_87, op_87 and fn_87 hold.
REQ-029 imem_valid_87 outside FETCH is ignored.
REQ-030 PC arithmetic is modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 0.

Reset
REQ-031 rst_87 high: state IDLE; PC <= RESET_PC_87; imem_req_87 = 0; instr_87 = 0; instr_valid_87 = 0; pc_plus4_87 = 0; skid and discard flag cleared.
REQ-032 Reset mid-request drops the outstanding response; any imem_valid_87 during reset is ignored.

Configuration
REQ-033 Macro FETCH_DELAY_SLOT_EN.
- Defined: on redirect, the next sequential instruction (skid, coincident or pending response) is delivered to IF/ID as a valid delay-slot instruction; the following fetch uses the target.
- Undefined: REQ-023 to REQ-026 apply and no delay slot exists.

Verification
REQ-034 Reset, then zero-wait memory returning 32'h2008_0005: addresses 0,4,8 issue on consecutive cycles; instr_87 = 32'h2008_0005; op_87 = 6'h08.
REQ-035 stall_87 high 3 cycles while a response returns: -> SKID; imem_req_87 low; IF/ID holds; after release the skid word appears one cycle later, then fetch resumes at PC+4.
REQ-036 jump_sel_87 = 01, j_target_87 = 32'h0000_0040, coincident with imem_valid_87: one bubble; next imem_addr_87 = 32'h40.
REQ-037 branch_taken_87 with target 32'h80 and jump_sel_87 = 10 with jr_target_87 = 32'hC0 in the same cycle, while a response is pending 2 cycles: response dropped; next address 32'h80.
REQ-038 FETCH_DELAY_SLOT_EN defined, J to 32'h100 issued while instruction at 32'h14 is in flight: 32'h14's instruction is delivered valid; next address 32'h100.
REQ-039 rst_87 asserted while a request is outstanding, with imem_valid_87 high on the following cycle: the response is ignored; the first post-reset address equals RESET_PC_87.
